// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and sizing constants for the data-memory responder
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W = 4;
endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: DEPTH x 32 word store with synchronous byte-lane writes and combinational read
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [IW-1:0]           idx_i,
  input  logic [31:0]             wdata_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  output logic [31:0]             rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    for (int b = 0; b < WORD_BYTES; b++)
      if (we_i && be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready word memory responder with programmable wait states.
// Define MEM_RESPONDER_BYTE_STRB_EN to add the req_be per-byte store strobe.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_STRB_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LATENCY > 0 ? LATENCY - 1 : 0);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic we_q, err_q, err_d;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic [3:0] be_q, be_in;
  logic idle, to_resp, acc_we, acc_err, wr_en;
  logic [31:0] acc_addr, acc_wdata, off, rd;
  logic [3:0] acc_be;
`ifdef MEM_RESPONDER_BYTE_STRB_EN
  assign be_in = req_be;
`else
  assign be_in = 4'hF;
`endif
  // With zero latency the access happens on the accept edge, so use the live request fields
  assign idle      = state_q == IDLE;
  assign acc_we    = idle ? req_we : we_q;
  assign acc_addr  = idle ? req_addr : addr_q;
  assign acc_wdata = idle ? req_wdata : wdata_q;
  assign acc_be    = idle ? be_in : be_q;
  assign off       = acc_addr - BASE_ADDR;
  assign acc_err   = (|off[1:0]) || ({2'b0, off[31:2]} >= 32'(DEPTH));
  assign to_resp   = idle ? (req_valid && LATENCY == 0) : (state_q == BUSY && cnt_q == '0);
  assign wr_en     = to_resp && acc_we && !acc_err && !reset;
  mem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (wr_en),
    .idx_i   (off[IW+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (rd)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LATENCY == 0 ? RESP : BUSY;
        cnt_d   = LAT_LD;
      end
      BUSY: begin
        state_d = cnt_q == '0 ? RESP : BUSY;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (to_resp) begin
      rdata_d = (acc_err || acc_we) ? 32'h0 : rd;
      err_d   = acc_err;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (idle && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= be_in;
      end
    end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule
